wrr_lock_arbiter: RTL and testbench

- Weighted round-robin arbiter for the AXI Stream Switch output ports. It is the parametrised successor of the index-based round-robin arbiter.
- Adds per-requester weights (credits), an optional packet lock that holds a grant until the TLAST beat, and a registered grant.
- Sits between the N input-port request lines and one output-port mux; gnt_id_o drives the mux select.

---
 rtl/wrr_lock_arbiter_if.sv | 31 +++
 rtl/wrr_lock_arbiter.sv | 121 ++++++++++++
 tb/tb_wrr_lock_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wrr_lock_arbiter_if.sv
// wrr_lock_arbiter_if: request/grant bundle between the input ports and one output-port arbiter.
//   req_i, req_last_i  per-port TVALID / TLAST toward this output
//   weight_i           per-port weights, field i = weight_i[i*WEIGHT_W +: WEIGHT_W]
//   gnt_rdy_i          downstream TREADY of the output port
//   req_ack_o          per-port beat accepted
//   gnt_o, gnt_id_o    one-hot grant and its index (mux select)
//   gnt_vld_o          grant valid
interface wrr_lock_arbiter_if #(
    parameter int WIDTH_REQ    = 8,
    parameter int SIZE_POINTER = $clog2(WIDTH_REQ),
    parameter int WEIGHT_W     = 4
);
    logic [WIDTH_REQ-1:0]          req_i;
    logic [WIDTH_REQ-1:0]          req_last_i;
    logic [WIDTH_REQ*WEIGHT_W-1:0] weight_i;
    logic                          gnt_rdy_i;
    logic [WIDTH_REQ-1:0]          req_ack_o;
    logic [WIDTH_REQ-1:0]          gnt_o;
    logic [SIZE_POINTER-1:0]       gnt_id_o;
    logic                          gnt_vld_o;

    modport master (
        output req_i, req_last_i, weight_i, gnt_rdy_i,
        input  req_ack_o, gnt_o, gnt_id_o, gnt_vld_o
    );

    modport slave (
        input  req_i, req_last_i, weight_i, gnt_rdy_i,
        output req_ack_o, gnt_o, gnt_id_o, gnt_vld_o
    );
endinterface

// File: rtl/wrr_lock_arbiter.sv
// wrr_lock_arbiter: weighted round-robin arbiter with optional packet lock and registered grant.
//   clk    single clock, posedge
//   reset  synchronous active-high reset
//   bus    wrr_lock_arbiter_if slave: requests, TLASTs, weights, TREADY in; acks and grant out
module wrr_lock_arbiter #(
    parameter int WIDTH_REQ    = 8,
    parameter int SIZE_POINTER = $clog2(WIDTH_REQ),
    parameter int WEIGHT_W     = 4,
    parameter int LOCK_MODE    = 1
) (
    input logic               clk,
    input logic               reset,
    wrr_lock_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [SIZE_POINTER:0]   NREQ    = WIDTH_REQ[SIZE_POINTER:0];
    localparam logic [SIZE_POINTER-1:0] LAST_ID = NREQ[SIZE_POINTER-1:0] - 1'b1;
    localparam logic [WEIGHT_W-1:0]     ONE     = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [SIZE_POINTER-1:0] point_q, point_d, gnt_id_q, gnt_id_d, win;
    logic [WIDTH_REQ-1:0]    gnt_q, gnt_d;
    logic                    gnt_vld_q, gnt_vld_d, bound_q, bound_d;
    logic [WEIGHT_W-1:0]     credit_q, credit_d, win_weight;
    logic [SIZE_POINTER:0]   idx;
    logic                    found, cur_req, cur_last, beat, dec, rel;

    assign cur_req       = bus.req_i[gnt_id_q];
    assign cur_last      = bus.req_last_i[gnt_id_q];
    assign beat          = gnt_vld_q & bus.gnt_rdy_i & cur_req;
    // credits count packets in lock mode, beats otherwise
    assign dec           = beat & ((LOCK_MODE == 0) | cur_last);
    assign win_weight    = bus.weight_i[win*WEIGHT_W +: WEIGHT_W];
    assign bus.req_ack_o = {WIDTH_REQ{gnt_vld_q & bus.gnt_rdy_i}} & bus.req_i & gnt_q;
    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_id_o  = gnt_id_q;
    assign bus.gnt_vld_o = gnt_vld_q;

    // first request at or above point, wrapping modulo WIDTH_REQ (need not be a power of two)
    always_comb begin
        win   = gnt_id_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < WIDTH_REQ; k++) begin
            idx = {1'b0, point_q} + k[SIZE_POINTER:0];
            idx = (idx >= NREQ) ? idx - NREQ : idx;
            if (!found && bus.req_i[idx[SIZE_POINTER-1:0]]) begin
                win   = idx[SIZE_POINTER-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        point_d   = point_q;
        gnt_id_d  = gnt_id_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        credit_d  = credit_q;
        bound_d   = bound_q;
        rel       = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d   = GRANT;
                gnt_id_d  = win;
                gnt_d     = {{(WIDTH_REQ-1){1'b0}}, 1'b1} << win;
                gnt_vld_d = 1'b1;
                credit_d  = (win_weight == '0) ? ONE : win_weight;
                bound_d   = 1'b0;
            end
        end else begin
            credit_d = (dec && credit_q != '0) ? credit_q - ONE : credit_q;
            if (LOCK_MODE != 0) begin
                // boundary flag: between packets the lock may be dropped by the requester
                bound_d = beat ? cur_last : bound_q;
                rel     = (dec && credit_q <= ONE) || (bound_q && !cur_req);
            end else begin
                rel = (dec && credit_q <= ONE) || !cur_req;
            end
            if (rel) begin
                state_d   = IDLE;
                gnt_vld_d = 1'b0;
                gnt_d     = '0;
                bound_d   = 1'b0;
                point_d   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            point_q   <= '0;
            gnt_id_q  <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            credit_q  <= '0;
            bound_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            point_q   <= point_d;
            gnt_id_q  <= gnt_id_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            credit_q  <= credit_d;
            bound_q   <= bound_d;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (reset)
        gnt_vld_q |-> ($onehot(gnt_q) && gnt_q[gnt_id_q]));
    a_ack: assert property (@(posedge clk) disable iff (reset)
        (bus.req_ack_o & ~bus.req_i) == '0);
    a_id: assert property (@(posedge clk) disable iff (reset)
        {1'b0, gnt_id_q} < NREQ);
    // any pending request in IDLE is granted on the next edge; rotation makes this starvation-free
    a_live: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE && found) |=> gnt_vld_q);
endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// tb_wrr_lock_arbiter: directed checks of three arbiter configurations (8/beat, 8/lock, 5/beat).
module tb_wrr_lock_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cnt [2];

    always #5 clk = ~clk;

    wrr_lock_arbiter_if #(.WIDTH_REQ(8), .WEIGHT_W(4)) ia ();
    wrr_lock_arbiter_if #(.WIDTH_REQ(8), .WEIGHT_W(4)) ib ();
    wrr_lock_arbiter_if #(.WIDTH_REQ(5), .WEIGHT_W(4)) ic ();

    wrr_lock_arbiter #(.WIDTH_REQ(8), .WEIGHT_W(4), .LOCK_MODE(0)) ua (.clk(clk), .reset(reset), .bus(ia.slave));
    wrr_lock_arbiter #(.WIDTH_REQ(8), .WEIGHT_W(4), .LOCK_MODE(1)) ub (.clk(clk), .reset(reset), .bus(ib.slave));
    wrr_lock_arbiter #(.WIDTH_REQ(5), .WEIGHT_W(4), .LOCK_MODE(0)) uc (.clk(clk), .reset(reset), .bus(ic.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        ia.req_i = '0; ia.req_last_i = '0; ia.gnt_rdy_i = 1'b0; ia.weight_i = {8{4'h1}};
        ib.req_i = '0; ib.req_last_i = '0; ib.gnt_rdy_i = 1'b0; ib.weight_i = 32'h0000_0013;
        ic.req_i = '0; ic.req_last_i = '0; ic.gnt_rdy_i = 1'b0; ic.weight_i = {5{4'h1}};
        repeat (2) @(negedge clk);
        chk("rst_vld_a", ia.gnt_vld_o, 0);
        chk("rst_gnt_a", ia.gnt_o, 0);
        chk("rst_id_a", ia.gnt_id_o, 0);
        chk("rst_vld_b", ib.gnt_vld_o, 0);
        chk("rst_ack_b", ib.req_ack_o, 0);
        chk("rst_vld_c", ic.gnt_vld_o, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_vld", ia.gnt_vld_o, 0);
            chk("idle_gnt", ia.gnt_o, 0);
            chk("idle_id", ia.gnt_id_o, 0);
        end
        // beat-mode rotation over all 8 ports with one bubble between grants
        ia.req_i = 8'hFF;
        ia.gnt_rdy_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk("rr_vld", ia.gnt_vld_o, 1);
            chk("rr_id", ia.gnt_id_o, k % 8);
            chk("rr_ack", ia.req_ack_o, 1 << (k % 8));
            cyc();
            chk("rr_bubble", ia.gnt_vld_o, 0);
            chk("rr_bubble_ack", ia.req_ack_o, 0);
        end
        ia.req_i = '0;
        // five-port wrap: move point to 3, then alternate 4,0,4,0
        ic.req_i = 5'b00100;
        ic.gnt_rdy_i = 1'b1;
        cyc();
        chk("w5_pre_id", ic.gnt_id_o, 2);
        chk("w5_pre_ack", ic.req_ack_o, 5'b00100);
        cyc();
        chk("w5_pre_bubble", ic.gnt_vld_o, 0);
        ic.req_i = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("w5_vld", ic.gnt_vld_o, 1);
            chk("w5_id", ic.gnt_id_o, (k % 2 == 0) ? 4 : 0);
            chk("w5_gnt", ic.gnt_o, (k % 2 == 0) ? 5'b10000 : 5'b00001);
            cyc();
            chk("w5_bubble", ic.gnt_vld_o, 0);
        end
        ic.req_i = '0;
        // lock mode: port0 weight 3, port1 weight 1, both streaming 4-beat packets
        cnt[0] = 0;
        cnt[1] = 0;
        ib.req_i = 8'h03;
        ib.gnt_rdy_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < ((p == 0) ? 12 : 4); i++) begin
                    cyc();
                    ib.req_last_i = {6'b0, cnt[1] == 3, cnt[0] == 3};
                    chk("lk_ack", ib.req_ack_o, 1 << p);
                    chk("lk_id", ib.gnt_id_o, p);
                    for (int q = 0; q < 2; q++) if (ib.req_ack_o[q]) cnt[q] = (cnt[q] + 1) % 4;
                end
                cyc();
                ib.req_last_i = {6'b0, cnt[1] == 3, cnt[0] == 3};
                chk("lk_bubble", ib.gnt_vld_o, 0);
            end
        end
        ib.req_i = '0;
        ib.req_last_i = '0;
        // lock hold through stall and mid-packet drop; release needs last beat then drop
        ib.weight_i = 32'h0000_0200;
        ib.req_i = 8'h04;
        cyc();
        chk("hold_grant_id", ib.gnt_id_o, 2);
        chk("hold_beat1", ib.req_ack_o, 8'h04);
        ib.gnt_rdy_i = 1'b0;
        #1 chk("hold_stall_ack", ib.req_ack_o, 0);
        cyc();
        chk("hold_stall_vld", ib.gnt_vld_o, 1);
        ib.gnt_rdy_i = 1'b1;
        #1 chk("hold_beat2", ib.req_ack_o, 8'h04);
        cyc();
        ib.req_i = '0;
        #1 chk("hold_drop_ack", ib.req_ack_o, 0);
        cyc();
        chk("hold_drop_vld", ib.gnt_vld_o, 1);
        chk("hold_drop_id", ib.gnt_id_o, 2);
        ib.req_i = 8'h04;
        ib.req_last_i = 8'h04;
        #1 chk("hold_last_beat", ib.req_ack_o, 8'h04);
        cyc();
        chk("hold_bound_vld", ib.gnt_vld_o, 1);
        ib.req_i = '0;
        ib.req_last_i = '0;
        cyc();
        chk("hold_rel_vld", ib.gnt_vld_o, 0);
        chk("hold_rel_gnt", ib.gnt_o, 0);
        chk("hold_rel_id", ib.gnt_id_o, 2);
        // reset mid-packet: point 3 picks port5, after reset point 0 picks port0
        ib.weight_i = 32'h0030_0003;
        ib.req_i = 8'h21;
        cyc();
        chk("mrst_id", ib.gnt_id_o, 5);
        chk("mrst_beat1", ib.req_ack_o, 8'h20);
        cyc();
        chk("mrst_beat2", ib.req_ack_o, 8'h20);
        reset = 1'b1;
        cyc();
        chk("mrst_vld", ib.gnt_vld_o, 0);
        chk("mrst_gnt", ib.gnt_o, 0);
        chk("mrst_ack", ib.req_ack_o, 0);
        chk("mrst_id0", ib.gnt_id_o, 0);
        reset = 1'b0;
        cyc();
        chk("mrst_regrant_vld", ib.gnt_vld_o, 1);
        chk("mrst_regrant_id", ib.gnt_id_o, 0);
        ib.req_i = '0;
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
